// File: rtl/issue_scheduler.sv
// Oldest-first issue select for the reservation station, with structural hazard
// tracking for a non-pipelined multiplier and a single outstanding memory op.
module issue_scheduler #(
    parameter int N_WAY    = 2,
    parameter int N_RS     = 8,
    parameter int AGE_W    = 4,
    parameter int MULT_LAT = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_RS-1:0]                  entry_valid,
    input  logic [N_RS-1:0]                  entry_ready,
    input  logic [N_RS*AGE_W-1:0]            entry_age,
    input  logic [N_RS*2-1:0]                entry_fu,
    input  logic                             ex_stall,
    input  logic                             mem_done,
    output logic [N_RS-1:0]                  grant,
    output logic [N_WAY*$clog2(N_RS)-1:0]    issue_idx,
    output logic [N_WAY-1:0]                 slot_valid,
    output logic [$clog2(N_WAY):0]           issue_num,
    output logic                             mult_busy,
    output logic                             mem_busy
);

    localparam int IDX_W = $clog2(N_RS);
    localparam int CNT_W = $clog2(MULT_LAT + 1);
    localparam int NUM_W = $clog2(N_WAY) + 1;

    localparam logic [1:0] FU_MULT = 2'b01;
    localparam logic [1:0] FU_MEM  = 2'b10;
    localparam logic [1:0] FU_ILL  = 2'b11;

    typedef enum logic {M_IDLE, M_BUSY} mem_state_t;

    mem_state_t             mem_state_q, mem_state_d;
    logic [CNT_W-1:0]       mult_cnt_q, mult_cnt_d;

    logic [N_RS-1:0]        elig, avail, grant_raw;
    logic [N_WAY-1:0]       sv_raw;
    logic [N_WAY*IDX_W-1:0] idx_raw;
    logic                   mult_taken, mem_taken, found;
    logic                   mult_ok, mem_ok;
    logic [IDX_W-1:0]       best;
    logic [AGE_W-1:0]       best_age;
    logic [1:0]             best_fu, fu_i;
    logic                   block_issue, mult_fire, mem_fire;

    // Each slot greedily takes the oldest remaining candidate; a slot skips a
    // second MULT/MEM rather than stopping, so younger ALU ops still issue.
    always_comb begin
        mult_ok    = (mult_cnt_q == '0);
        mem_ok     = (mem_state_q == M_IDLE) || mem_done;
        elig       = '0;
        fu_i       = '0;
        grant_raw  = '0;
        sv_raw     = '0;
        idx_raw    = '0;
        mult_taken = 1'b0;
        mem_taken  = 1'b0;
        found      = 1'b0;
        best       = '0;
        best_age   = '0;
        best_fu    = '0;
        for (int i = 0; i < N_RS; i++) begin
            fu_i    = entry_fu[2*i +: 2];
            elig[i] = entry_valid[i] && entry_ready[i] && (fu_i != FU_ILL) &&
                      ((fu_i != FU_MULT) || mult_ok) && ((fu_i != FU_MEM) || mem_ok);
        end
        avail = elig;
        for (int k = 0; k < N_WAY; k++) begin
            found    = 1'b0;
            best     = '0;
            best_age = '0;
            best_fu  = '0;
            for (int i = 0; i < N_RS; i++) begin
                fu_i = entry_fu[2*i +: 2];
                if (avail[i] && !((fu_i == FU_MULT) && mult_taken) &&
                    !((fu_i == FU_MEM) && mem_taken) &&
                    (!found || (entry_age[i*AGE_W +: AGE_W] < best_age))) begin
                    found    = 1'b1;
                    best     = IDX_W'(i);
                    best_age = entry_age[i*AGE_W +: AGE_W];
                    best_fu  = fu_i;
                end
            end
            if (found) begin
                grant_raw[best]            = 1'b1;
                avail[best]                = 1'b0;
                sv_raw[k]                  = 1'b1;
                idx_raw[k*IDX_W +: IDX_W]  = best;
                if (best_fu == FU_MULT) mult_taken = 1'b1;
                if (best_fu == FU_MEM)  mem_taken  = 1'b1;
            end
        end
    end

    assign block_issue = ex_stall || reset;
    assign grant       = block_issue ? '0 : grant_raw;
    assign slot_valid  = block_issue ? '0 : sv_raw;
    assign issue_idx   = block_issue ? '0 : idx_raw;
    assign mult_fire   = mult_taken && !block_issue;
    assign mem_fire    = mem_taken && !block_issue;

    always_comb begin
        issue_num = '0;
        for (int k = 0; k < N_WAY; k++) begin
            issue_num = issue_num + NUM_W'(slot_valid[k]);
        end
    end

    // Occupancy counter keeps counting down even while issue is stalled.
    always_comb begin
        mult_cnt_d = mult_cnt_q;
        if (mult_fire) begin
            mult_cnt_d = CNT_W'(MULT_LAT - 1);
        end else if (mult_cnt_q != '0) begin
            mult_cnt_d = mult_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        mem_state_d = mem_state_q;
        case (mem_state_q)
            M_IDLE: if (mem_fire) mem_state_d = M_BUSY;
            M_BUSY: if (mem_done && !mem_fire) mem_state_d = M_IDLE;
            default: mem_state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_cnt_q  <= '0;
            mem_state_q <= M_IDLE;
        end else begin
            mult_cnt_q  <= mult_cnt_d;
            mem_state_q <= mem_state_d;
        end
    end

    assign mult_busy = (mult_cnt_q != '0);
    assign mem_busy  = (mem_state_q == M_BUSY);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: a table of single-cycle select vectors plus
// hand-written multi-cycle sequences for the multiplier, memory FSM, stall and reset.
module tb_issue_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  entry_valid, entry_ready;
    logic [31:0] entry_age;
    logic [15:0] entry_fu;
    logic        ex_stall, mem_done;
    logic [7:0]  grant;
    logic [5:0]  issue_idx;
    logic [1:0]  slot_valid;
    logic [1:0]  issue_num;
    logic        mult_busy, mem_busy;

    int errors = 0;
    int checks = 0;

    issue_scheduler #(.N_WAY(2), .N_RS(8), .AGE_W(4), .MULT_LAT(4)) dut (
        .clock(clock), .reset(reset),
        .entry_valid(entry_valid), .entry_ready(entry_ready),
        .entry_age(entry_age), .entry_fu(entry_fu),
        .ex_stall(ex_stall), .mem_done(mem_done),
        .grant(grant), .issue_idx(issue_idx), .slot_valid(slot_valid),
        .issue_num(issue_num), .mult_busy(mult_busy), .mem_busy(mem_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  valid;
        logic [7:0]  ready;
        logic [31:0] age;
        logic [15:0] fu;
        logic        stall;
        logic [7:0]  exp_grant;
        logic [5:0]  exp_idx;
        logic [1:0]  exp_sv;
        logic [1:0]  exp_num;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_sel(input string tag, input logic [7:0] eg, input logic [5:0] ei,
                             input logic [1:0] esv, input logic [1:0] en);
        check({tag, " grant"}, 32'(grant), 32'(eg));
        check({tag, " issue_idx"}, 32'(issue_idx), 32'(ei));
        check({tag, " slot_valid"}, 32'(slot_valid), 32'(esv));
        check({tag, " issue_num"}, 32'(issue_num), 32'(en));
    endtask

    task automatic drive(input logic [7:0] v, input logic [7:0] r, input logic [31:0] a,
                         input logic [15:0] f, input logic st, input logic md);
        entry_valid = v;
        entry_ready = r;
        entry_age   = a;
        entry_fu    = f;
        ex_stall    = st;
        mem_done    = md;
    endtask

    // Reset pulse ends on a falling edge; caller drives inputs right after.
    task automatic pulse_reset();
        reset = 1'b1;
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);

        vecs[0]  = '{8'hFF, 8'hFF, 32'h76543210, 16'h0000, 1'b0, 8'h03, 6'h08, 2'b11, 2'd2};
        vecs[1]  = '{8'h49, 8'hFF, 32'h02001005, 16'h0000, 1'b0, 8'h48, 6'h33, 2'b11, 2'd2};
        vecs[2]  = '{8'hFF, 8'hFF, 32'h01234567, 16'h0000, 1'b0, 8'hC0, 6'h37, 2'b11, 2'd2};
        vecs[3]  = '{8'hFF, 8'hFF, 32'h00000000, 16'h0000, 1'b0, 8'h03, 6'h08, 2'b11, 2'd2};
        vecs[4]  = '{8'h10, 8'hFF, 32'h76543210, 16'h0000, 1'b0, 8'h10, 6'h04, 2'b01, 2'd1};
        vecs[5]  = '{8'hFF, 8'h00, 32'h76543210, 16'h0000, 1'b0, 8'h00, 6'h00, 2'b00, 2'd0};
        vecs[6]  = '{8'hFF, 8'hFF, 32'h76543210, 16'h000F, 1'b0, 8'h0C, 6'h1A, 2'b11, 2'd2};
        vecs[7]  = '{8'hFF, 8'hFF, 32'h76543210, 16'h0005, 1'b0, 8'h05, 6'h10, 2'b11, 2'd2};
        vecs[8]  = '{8'hFF, 8'hFF, 32'h76543210, 16'h000A, 1'b0, 8'h05, 6'h10, 2'b11, 2'd2};
        vecs[9]  = '{8'hFF, 8'hFF, 32'h76543210, 16'h0009, 1'b0, 8'h03, 6'h08, 2'b11, 2'd2};
        vecs[10] = '{8'hFF, 8'hFF, 32'h76543210, 16'h0000, 1'b1, 8'h00, 6'h00, 2'b00, 2'd0};
        vecs[11] = '{8'h00, 8'hFF, 32'h76543210, 16'h0000, 1'b0, 8'h00, 6'h00, 2'b00, 2'd0};
        vecs[12] = '{8'hFF, 8'hA0, 32'h76543210, 16'h0000, 1'b0, 8'hA0, 6'h3D, 2'b11, 2'd2};

        @(negedge clock);
        @(negedge clock);

        // Reset gating with eligible ALU entries, then release
        drive(8'hFF, 8'hFF, 32'h76543210, 16'h0000, 1'b0, 1'b0);
        #1;
        check_sel("in_reset", 8'h00, 6'h00, 2'b00, 2'd0);
        check("in_reset mult_busy", 32'(mult_busy), 32'd0);
        check("in_reset mem_busy", 32'(mem_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_sel("after_reset", 8'h03, 6'h08, 2'b11, 2'd2);

        for (int i = 0; i < 13; i++) begin
            pulse_reset();
            drive(vecs[i].valid, vecs[i].ready, vecs[i].age, vecs[i].fu, vecs[i].stall, 1'b0);
            #1;
            check_sel($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx,
                      vecs[i].exp_sv, vecs[i].exp_num);
        end

        // Multiplier occupancy: e0 MULT age1, e1 MULT age2, e2 ALU age3
        pulse_reset();
        drive(8'h07, 8'h0F, 32'h00004321, 16'h0005, 1'b0, 1'b0);
        #1;
        check_sel("mult c0", 8'h05, 6'h10, 2'b11, 2'd2);
        check("mult c0 busy", 32'(mult_busy), 32'd0);
        next_cycle();
        drive(8'h0A, 8'h0F, 32'h00004321, 16'h0005, 1'b0, 1'b0);
        #1;
        check_sel("mult c1 alu_bypass", 8'h08, 6'h03, 2'b01, 2'd1);
        check("mult c1 busy", 32'(mult_busy), 32'd1);
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            drive(8'h02, 8'h0F, 32'h00004321, 16'h0005, 1'b0, 1'b0);
            #1;
            check(ver_name("mult grant c", c), 32'(grant), 32'h00);
            check(ver_name("mult busy c", c), 32'(mult_busy), 32'd1);
        end
        next_cycle();
        #1;
        check_sel("mult c4", 8'h02, 6'h01, 2'b01, 2'd1);
        check("mult c4 busy", 32'(mult_busy), 32'd0);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("mult c5 busy", 32'(mult_busy), 32'd1);

        // Memory FSM: e0 MEM age1, e1 MEM age2
        pulse_reset();
        drive(8'h03, 8'h03, 32'h00000021, 16'h000A, 1'b0, 1'b0);
        #1;
        check_sel("mem c0", 8'h01, 6'h00, 2'b01, 2'd1);
        check("mem c0 busy", 32'(mem_busy), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            drive(8'h02, 8'h03, 32'h00000021, 16'h000A, 1'b0, 1'b0);
            #1;
            check(ver_name("mem grant c", c), 32'(grant), 32'h00);
            check(ver_name("mem busy c", c), 32'(mem_busy), 32'd1);
        end
        next_cycle();
        drive(8'h02, 8'h03, 32'h00000021, 16'h000A, 1'b0, 1'b1);
        #1;
        check_sel("mem c3 done+grant", 8'h02, 6'h01, 2'b01, 2'd1);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("mem c4 busy stays", 32'(mem_busy), 32'd1);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b1);
        #1;
        check("mem c5 busy", 32'(mem_busy), 32'd1);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b1);
        #1;
        check("mem c6 idle", 32'(mem_busy), 32'd0);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("mem c7 done_in_idle", 32'(mem_busy), 32'd0);

        // Stall: counter keeps draining, nothing issues
        pulse_reset();
        drive(8'h01, 8'h01, 32'h00000000, 16'h0001, 1'b0, 1'b0);
        #1;
        check("stall c0 grant", 32'(grant), 32'h01);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive(8'h0E, 8'h0E, 32'h00003210, 16'h0000, 1'b1, 1'b0);
            #1;
            check_sel(ver_name("stall c", c), 8'h00, 6'h00, 2'b00, 2'd0);
            check(ver_name("stall busy c", c), 32'(mult_busy), 32'd1);
        end
        next_cycle();
        drive(8'h01, 8'h01, 32'h00000000, 16'h0001, 1'b1, 1'b0);
        #1;
        check("stall c4 busy", 32'(mult_busy), 32'd0);
        check("stall c4 grant", 32'(grant), 32'h00);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("stall c5 no_load", 32'(mult_busy), 32'd0);

        // Async reset mid-op with mult_cnt=2 and memory busy
        pulse_reset();
        drive(8'h03, 8'h03, 32'h00000010, 16'h0009, 1'b0, 1'b0);
        #1;
        check("areset c0 grant", 32'(grant), 32'h03);
        next_cycle();
        drive(8'h00, 8'h00, 32'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        check("areset pre mult_busy", 32'(mult_busy), 32'd1);
        check("areset pre mem_busy", 32'(mem_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("areset mult_busy", 32'(mult_busy), 32'd0);
        check("areset mem_busy", 32'(mem_busy), 32'd0);
        check("areset grant", 32'(grant), 32'h00);
        @(negedge clock);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic string ver_name(input string base, input int c);
        return $sformatf("%s%0d", base, c);
    endfunction

endmodule
